// File: rtl/fetch_run_ctrl_pkg.sv
// Shared definitions for the fetch run/step scheduler: CPU mode codes seen by IFetch,
// scheduler state encoding and the syscall opcode.
package fetch_run_ctrl_pkg;

  localparam logic [3:0]  MODE_IDLE     = 4'd0;
  localparam logic [3:0]  MODE_RUN      = 4'd5;
  localparam logic [3:0]  MODE_CLEAR    = 4'd6;
  localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROG  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_STEP  = 3'd4,
    ST_HALT  = 3'd5
  } run_state_e;

  // IFetch advances the PC in RUN and STEP and zeroes it in CLEAR.
  function automatic logic [3:0] mode_of(run_state_e s);
    case (s)
      ST_CLEAR:        return MODE_CLEAR;
      ST_RUN, ST_STEP: return MODE_RUN;
      default:         return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_run_ctrl_btn_edge.sv
// Raw board button to one-cycle press pulse: 2-flop synchronizer, level debounce,
// registered rising-edge detect. Press-to-pulse latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
module fetch_run_ctrl_btn_edge #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [1:0]  sync_q;
  logic [15:0] cnt_q;
  logic        level_q;
  logic        level_d_q;

  // cnt_q counts consecutive cycles the synchronized input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (({1'b0, cnt_q} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES}) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
      level_d_q <= level_q;
      pulse     <= level_q & ~level_d_q;
    end
  end

endmodule

// File: rtl/fetch_run_ctrl.sv
// Run/step scheduler for the fetch stage: turns board buttons, UART programming status,
// breakpoint and syscall detection into the CPU mode driven to IFetch.
module fetch_run_ctrl
  import fetch_run_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [3:0]  CLEAR_CYCLES    = 4'd2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        step_i,
  input  logic        halt_i,
  input  logic        upg_rst_i,
  input  logic        upg_done_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic        bp_en_i,
  input  logic [13:0] bp_addr_i,
  output logic [3:0]  mode_o,
  output logic        upg_mode_o,
  output logic        running_o,
  output logic [2:0]  state_o,
  output logic [31:0] cycle_cnt_o
);

  logic start_p, step_p, halt_p;

  fetch_run_ctrl_btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk_i), .rst_n(rst_n_i), .btn(start_i), .pulse(start_p));
  fetch_run_ctrl_btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk_i), .rst_n(rst_n_i), .btn(step_i), .pulse(step_p));
  fetch_run_ctrl_btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt (
    .clk(clk_i), .rst_n(rst_n_i), .btn(halt_i), .pulse(halt_p));

  run_state_e  state_q, state_d;
  logic [3:0]  clr_cnt_q;
  logic        go_run_q;
  logic        skip_bp_q;
  logic [31:0] cycle_cnt_q;
  logic        clr_done;
  logic        enter_clear;
  logic        bp_hit;
  logic        syscall_hit;
  logic        pc_hi_unused;

  // Breakpoints cover the 14-bit instruction memory; upper PC bits play no part.
  assign pc_hi_unused = ^pc_i[31:14];

  assign upg_mode_o  = ~upg_rst_i & ~upg_done_i;
  assign clr_done    = ({1'b0, clr_cnt_q} + 5'd1) >= {1'b0, CLEAR_CYCLES};
  assign bp_hit      = bp_en_i & (pc_i[13:0] == bp_addr_i) & ~skip_bp_q;
  assign syscall_hit = (instruction_i == SYSCALL_INSTR);
  assign enter_clear = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);

  always_comb begin
    state_d = state_q;
    if (upg_mode_o) begin
      state_d = ST_PROG;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_p) state_d = ST_CLEAR;
        ST_PROG:  state_d = ST_CLEAR;
        ST_CLEAR: if (clr_done) state_d = go_run_q ? ST_RUN : ST_HALT;
        ST_RUN:   if (halt_p || syscall_hit || bp_hit) state_d = ST_HALT;
        ST_HALT: begin
          if (start_p)     state_d = ST_RUN;
          else if (step_p) state_d = ST_STEP;
        end
        ST_STEP:  state_d = ST_HALT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      go_run_q    <= 1'b0;
      skip_bp_q   <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      if (enter_clear)             clr_cnt_q <= '0;
      else if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + 4'd1;

      // A button start runs after the clear; a clear following programming parks in HALT.
      if (state_q == ST_IDLE && state_d == ST_CLEAR)      go_run_q <= 1'b1;
      else if (state_q == ST_PROG && state_d == ST_CLEAR) go_run_q <= 1'b0;

      // Any entry into RUN masks the breakpoint compare for exactly its first cycle.
      skip_bp_q <= (state_d == ST_RUN) && (state_q != ST_RUN);

      if (enter_clear)
        cycle_cnt_q <= '0;
      else if (mode_o == MODE_RUN && cycle_cnt_q != 32'hFFFF_FFFF)
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign mode_o      = mode_of(state_q);
  assign running_o   = (state_q == ST_RUN);
  assign state_o     = state_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_fetch_run_ctrl.sv
// Scenario bench for fetch_run_ctrl with a small IFetch model driving pc_i/instruction_i.
module tb_fetch_run_ctrl;

  localparam int DEB       = 4;
  localparam int CLR       = 2;
  localparam int FSM_LAT   = 2 + DEB + 1 + 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_PROG = 3'd1, S_CLEAR = 3'd2,
                         S_RUN  = 3'd3, S_HALT = 3'd5;
  localparam logic [31:0] SYSCALL = 32'h0000_000C;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, start, step, halt, upg_rst, upg_done, bp_en;
  logic [31:0] pc_model, instr;
  logic [13:0] bp_addr;
  logic [3:0]  mode;
  logic        upg_mode, running;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] syscall_at = 32'hFFFF_FFFF;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 1'b0;
  int n5, run5, max_run5;

  fetch_run_ctrl #(.DEBOUNCE_CYCLES(16'(DEB)), .CLEAR_CYCLES(4'(CLR))) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .step_i(step), .halt_i(halt),
    .upg_rst_i(upg_rst), .upg_done_i(upg_done), .pc_i(pc_model), .instruction_i(instr),
    .bp_en_i(bp_en), .bp_addr_i(bp_addr), .mode_o(mode), .upg_mode_o(upg_mode),
    .running_o(running), .state_o(state), .cycle_cnt_o(cycle_cnt));

  always #5 clk = ~clk;

  // IFetch model: PC moves on the falling edge according to the mode it sees.
  initial begin
    pc_model = 32'd0;
    instr    = NOP;
    forever begin
      @(negedge clk);
      if (mode === 4'd6)      pc_model = 32'd0;
      else if (mode === 4'd5) pc_model = pc_model + 32'd1;
      instr = (pc_model == syscall_at) ? SYSCALL : NOP;
    end
  end

  // Counts cycles spent in the advance mode and the longest unbroken run of them.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        if (mode === 4'd5) begin
          n5++; run5++;
          if (run5 > max_run5) max_run5 = run5;
        end else run5 = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic s, input logic st, input logic h, input int hold);
    start = s; step = st; halt = h;
    repeat (hold) tick();
    start = 1'b0; step = 1'b0; halt = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int budget, input string name);
    int n = 0;
    while (state !== exp && n < budget) begin tick(); n++; end
    checks++;
    if (state !== exp) begin
      fails++; $display("FAIL %s: state %0d expected %0d after %0d cycles", name, state, exp, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; step = 1'b0; halt = 1'b0;
    upg_rst = 1'b1; upg_done = 1'b0; bp_en = 1'b0; bp_addr = '0;
    repeat (3) tick();
    checks++; if (state !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (mode !== 4'd0) begin fails++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    checks++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (cycle_cnt !== 32'd0) begin fails++; $display("FAIL reset_cycle_cnt: got %0h expected 0", cycle_cnt); end
    checks++; if (upg_mode !== 1'b0) begin fails++; $display("FAIL upg_mode_idle: got %b expected 0", upg_mode); end
    upg_rst = 1'b0; #1;
    checks++; if (upg_mode !== 1'b1) begin fails++; $display("FAIL upg_mode_active: got %b expected 1", upg_mode); end
    tick();
    checks++; if (state !== S_IDLE) begin fails++; $display("FAIL reset_dominates: state %0d expected 0", state); end
    upg_done = 1'b1; #1;
    checks++; if (upg_mode !== 1'b0) begin fails++; $display("FAIL upg_mode_done: got %b expected 0", upg_mode); end
    upg_rst = 1'b1; upg_done = 1'b0;
    tick(); rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (state !== S_IDLE) begin fails++; $display("FAIL idle_after_reset: state %0d expected 0", state); end
  endtask

  task automatic test_start_run();
    int n = 0;
    int k;
    start = 1'b1;
    while (state !== S_CLEAR && n < FSM_LAT + 6) begin tick(); n++; end
    start = 1'b0;
    checks++; if (n != FSM_LAT) begin fails++; $display("FAIL start_latency: got %0d cycles expected %0d", n, FSM_LAT); end
    checks++; if (mode !== 4'd6) begin fails++; $display("FAIL clear_mode_1: got %0d expected 6", mode); end
    checks++; if (cycle_cnt !== 32'd0) begin fails++; $display("FAIL clear_cnt: got %0h expected 0", cycle_cnt); end
    tick();
    checks++; if (mode !== 4'd6) begin fails++; $display("FAIL clear_mode_2: got %0d expected 6", mode); end
    tick();
    checks++; if (state !== S_RUN || mode !== 4'd5 || running !== 1'b1) begin
      fails++; $display("FAIL run_entry: state %0d mode %0d running %b expected 3/5/1", state, mode, running);
    end
    checks++; if (cycle_cnt !== 32'd0) begin fails++; $display("FAIL run_cnt_start: got %0h expected 0", cycle_cnt); end
    k = $urandom_range(3, 12);
    repeat (k) tick();
    checks++; if (cycle_cnt !== 32'(k)) begin fails++; $display("FAIL run_cnt: got %0d expected %0d", cycle_cnt, k); end
  endtask

  task automatic test_breakpoint();
    logic [13:0] bp;
    bit ok_run;
    for (int it = 0; it < 3; it++) begin
      bp = pc_model[13:0] + 14'($urandom_range(3, 15));
      bp_addr = bp; bp_en = 1'b1;
      wait_state(S_HALT, 40, "bp_halt");
      checks++; if (pc_model[13:0] !== bp || mode !== 4'd0) begin
        fails++; $display("FAIL bp_stop_pc: pc %0h mode %0d expected pc %0h mode 0", pc_model, mode, bp);
      end
      repeat (2) tick();
      checks++; if (pc_model[13:0] !== bp) begin fails++; $display("FAIL bp_pc_held: got %0h expected %0h", pc_model, bp); end
      press(1'b1, 1'b0, 1'b0, 8);
      wait_state(S_RUN, 4, "bp_resume");
      ok_run = 1'b1;
      repeat (6) begin tick(); if (state !== S_RUN) ok_run = 1'b0; end
      checks++; if (!ok_run || pc_model[13:0] == bp) begin
        fails++; $display("FAIL bp_no_rehalt: state %0d pc %0h expected RUN past %0h", state, pc_model, bp);
      end
    end
    bp_en = 1'b0;
  endtask

  task automatic test_run_ignore();
    press(1'b1, 1'b1, 1'b0, 8);
    repeat (6) tick();
    checks++; if (state !== S_RUN) begin fails++; $display("FAIL run_ignores_start_step: state %0d expected 3", state); end
    press(1'b0, 1'b0, 1'b1, 8);
    wait_state(S_HALT, 4, "halt_button");
    checks++; if (mode !== 4'd0) begin fails++; $display("FAIL halt_mode: got %0d expected 0", mode); end
  endtask

  task automatic test_step();
    logic [31:0] cnt0 = cycle_cnt;
    n5 = 0; run5 = 0; max_run5 = 0; mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1, 1'b0, 8);
      repeat ($urandom_range(8, 12)) tick();
    end
    mon_en = 1'b0;
    checks++; if (n5 != 3) begin fails++; $display("FAIL step_count: got %0d advance cycles expected 3", n5); end
    checks++; if (max_run5 != 1) begin fails++; $display("FAIL step_width: got %0d expected 1", max_run5); end
    checks++; if (cycle_cnt !== cnt0 + 32'd3) begin fails++; $display("FAIL step_cnt: got %0d expected %0d", cycle_cnt, cnt0 + 32'd3); end
    checks++; if (state !== S_HALT) begin fails++; $display("FAIL step_back_to_halt: state %0d expected 5", state); end
    press(1'b1, 1'b1, 1'b1, 8);
    wait_state(S_RUN, 4, "start_beats_step");
  endtask

  task automatic test_prog();
    upg_rst = 1'b0; upg_done = 1'b0; #1;
    checks++; if (upg_mode !== 1'b1) begin fails++; $display("FAIL prog_upg_mode: got %b expected 1", upg_mode); end
    tick();
    checks++; if (state !== S_PROG || mode !== 4'd0) begin
      fails++; $display("FAIL prog_entry: state %0d mode %0d expected 1/0", state, mode);
    end
    repeat (3) tick();
    checks++; if (state !== S_PROG) begin fails++; $display("FAIL prog_hold: state %0d expected 1", state); end
    upg_done = 1'b1;
    tick();
    checks++; if (state !== S_CLEAR || mode !== 4'd6 || cycle_cnt !== 32'd0) begin
      fails++; $display("FAIL prog_clear: state %0d mode %0d cnt %0h expected 2/6/0", state, mode, cycle_cnt);
    end
    tick();
    checks++; if (state !== S_CLEAR) begin fails++; $display("FAIL prog_clear_len: state %0d expected 2", state); end
    tick();
    checks++; if (state !== S_HALT || mode !== 4'd0) begin
      fails++; $display("FAIL prog_to_halt: state %0d mode %0d expected 5/0", state, mode);
    end
    upg_rst = 1'b1; upg_done = 1'b0;
  endtask

  task automatic test_syscall();
    logic [31:0] target;
    press(1'b1, 1'b0, 1'b0, 8);
    wait_state(S_RUN, 4, "syscall_resume");
    target = pc_model + 32'($urandom_range(3, 10));
    syscall_at = target;
    wait_state(S_HALT, 30, "syscall_halt");
    checks++; if (pc_model !== target || instr !== SYSCALL) begin
      fails++; $display("FAIL syscall_pc: pc %0h instr %0h expected pc %0h", pc_model, instr, target);
    end
    syscall_at = 32'hFFFF_FFFF;
  endtask

  task automatic test_saturate();
    logic [31:0] pre = 32'hFFFF_FFFC;
    @(negedge clk);
    force dut.cycle_cnt_q = pre;
    #1 release dut.cycle_cnt_q;
    tick();
    checks++; if (cycle_cnt !== pre) begin fails++; $display("FAIL sat_preload_hold: got %0h expected %0h", cycle_cnt, pre); end
    press(1'b1, 1'b0, 1'b0, 8);
    wait_state(S_RUN, 4, "sat_resume");
    repeat (2) tick();
    checks++; if (cycle_cnt !== pre + 32'd2) begin fails++; $display("FAIL sat_count: got %0h expected %0h", cycle_cnt, pre + 32'd2); end
    repeat (6) tick();
    checks++; if (cycle_cnt !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_hold: got %0h expected ffffffff", cycle_cnt); end
  endtask

  task automatic test_reset_midrun();
    checks++; if (state !== S_RUN) begin fails++; $display("FAIL midrun_precondition: state %0d expected 3", state); end
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    checks++; if (mode !== 4'd0 || state !== S_IDLE || running !== 1'b0) begin
      fails++; $display("FAIL async_reset: mode %0d state %0d running %b expected 0/0/0", mode, state, running);
    end
    checks++; if (cycle_cnt !== 32'd0) begin fails++; $display("FAIL async_reset_cnt: got %0h expected 0", cycle_cnt); end
    tick(); rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (state !== S_IDLE) begin fails++; $display("FAIL post_reset_idle: state %0d expected 0", state); end
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_breakpoint();
    test_run_ignore();
    test_step();
    test_prog();
    test_syscall();
    test_saturate();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
